// File: rtl/dekatron_chain_ctrl.sv
// Sequencer for a chain of one-hot decimal ring counters (dekatron cells).
// Handles INC/DEC with digit-by-digit carry/borrow ripple, plus parallel LOAD/CLR.
module dekatron_chain_ctrl #(
  parameter int unsigned DIGITS        = 3,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [1:0]            cmd,
  input  logic [4*DIGITS-1:0]   data,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic                  zero,
  output logic                  error,
  input  logic [10*DIGITS-1:0]  dek_out,
  output logic [DIGITS-1:0]     dek_step,
  output logic [DIGITS-1:0]     dek_enable,
  output logic                  dek_reverse,
  output logic                  dek_set,
  output logic [10*DIGITS-1:0]  dek_in
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPulse  = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [1:0] CmdInc  = 2'd0;
  localparam logic [1:0] CmdDec  = 2'd1;
  localparam logic [1:0] CmdLoad = 2'd2;

  localparam logic [CW-1:0]     SettleLast = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]     LastDigit  = IW'(DIGITS - 1);
  localparam logic [9:0]        Pos0       = 10'b0000000001;
  localparam logic [DIGITS-1:0] OneDigit   = DIGITS'(1);

  logic [1:0]           state_q, state_d;
  logic [1:0]           cmd_q, cmd_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 carry_q, carry_d;
  logic                 pend_q, pend_d;
  logic                 overflow_q, overflow_d;
  logic                 error_q, error_d;
  logic                 zero_q, zero_d;
  logic [DIGITS-1:0]    step_q, step_d;
  logic [DIGITS-1:0]    enable_q, enable_d;
  logic                 reverse_q, reverse_d;
  logic                 set_q, set_d;
  logic [10*DIGITS-1:0] dek_in_q, dek_in_d;

  logic                 start_step;
  logic [IW-1:0]        step_idx;
  logic                 step_is_dec;
  logic [9:0]           dig;
  logic                 is_count_q;

  function automatic logic [9:0] digit_of(input logic [10*DIGITS-1:0] bus,
                                          input logic [IW-1:0] sel);
    logic [9:0] r;
    r = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (sel == IW'(d)) r = bus[10*d +: 10];
    end
    return r;
  endfunction

  assign is_count_q = (cmd_q == CmdInc) || (cmd_q == CmdDec);

  always_comb begin
    zero_d = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (dek_out[10*d +: 10] != Pos0) zero_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    pend_d      = pend_q;
    overflow_d  = overflow_q;
    error_d     = error_q;
    step_d      = '0;
    enable_d    = enable_q;
    reverse_d   = reverse_q;
    set_d       = set_q;
    dek_in_d    = dek_in_q;
    start_step  = 1'b0;
    step_idx    = idx_q;
    step_is_dec = (cmd_q == CmdDec);
    dig         = '0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          cmd_d      = cmd;
          overflow_d = 1'b0;
          error_d    = 1'b0;
          pend_d     = 1'b0;
          carry_d    = 1'b0;
          idx_d      = '0;
          cnt_d      = '0;
          state_d    = StPulse;
          if ((cmd == CmdInc) || (cmd == CmdDec)) begin
            start_step  = 1'b1;
            step_idx    = '0;
            step_is_dec = (cmd == CmdDec);
          end else begin
            step_d    = '1;
            enable_d  = '1;
            set_d     = 1'b1;
            reverse_d = 1'b0;
            for (int unsigned d = 0; d < DIGITS; d++) begin
              if ((cmd == CmdLoad) && (data[4*d +: 4] <= 4'd9)) begin
                dek_in_d[10*d +: 10] = Pos0 << data[4*d +: 4];
              end else begin
                // Invalid BCD falls back to position 0 and flags the command.
                dek_in_d[10*d +: 10] = Pos0;
                if (cmd == CmdLoad) pend_d = 1'b1;
              end
            end
          end
        end
      end
      StPulse: begin
        state_d = StSettle;
        cnt_d   = '0;
      end
      StSettle: begin
        if (cnt_q != SettleLast) begin
          cnt_d = cnt_q + 1'b1;
        end else if (is_count_q && carry_q && (idx_q != LastDigit)) begin
          idx_d      = idx_q + 1'b1;
          step_idx   = idx_q + 1'b1;
          start_step = 1'b1;
          state_d    = StPulse;
        end else begin
          if (is_count_q && carry_q) overflow_d = 1'b1;
          error_d   = pend_q;
          enable_d  = '0;
          set_d     = 1'b0;
          reverse_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Carry/borrow is taken from the digit's position before its own step.
    if (start_step) begin
      dig       = digit_of(dek_out, step_idx);
      step_d    = OneDigit << step_idx;
      enable_d  = OneDigit << step_idx;
      reverse_d = step_is_dec;
      set_d     = 1'b0;
      if ($onehot(dig)) begin
        carry_d = step_is_dec ? dig[0] : dig[9];
      end else begin
        carry_d = 1'b0;
        pend_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_q      <= CmdInc;
      idx_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      pend_q     <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
      zero_q     <= 1'b0;
      step_q     <= '0;
      enable_q   <= '0;
      reverse_q  <= 1'b0;
      set_q      <= 1'b0;
      dek_in_q   <= {DIGITS{Pos0}};
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
      zero_q     <= zero_d;
      step_q     <= step_d;
      enable_q   <= enable_d;
      reverse_q  <= reverse_d;
      set_q      <= set_d;
      dek_in_q   <= dek_in_d;
    end
  end

  assign ready       = (state_q == StIdle);
  assign done        = (state_q == StDone);
  assign overflow    = overflow_q;
  assign error       = error_q;
  assign zero        = zero_q;
  assign dek_step    = step_q;
  assign dek_enable  = enable_q;
  assign dek_reverse = reverse_q;
  assign dek_set     = set_q;
  assign dek_in      = dek_in_q;

endmodule
